accum_cpu_core: RTL and testbench

Parametrised accumulator processor core: the generalised successor to the 8-bit general datapath and its external control strobes. Data width and memory depth are configurable. It integrates the fetch/execute state machine, instruction RAM, ALU and a ready/valid INPUT handshake. It sits at the top of the microprocessor, between program-load logic and the I/O pins.

---
 rtl/accum_cpu_pkg.sv | 24 ++
 rtl/accum_alu.sv | 31 +++
 rtl/accum_cpu_core.sv | 137 +++++++++++++
 tb/tb_accum_cpu_core.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_cpu_pkg.sv
// Shared types for the accumulator processor core: opcode and FSM state encodings.
package accum_cpu_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_INPUT = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/accum_alu.sv
// Two's complement add/subtract for the accumulator datapath.
// Build option ACC_SATURATE_EN clamps signed overflow to max/min instead of wrapping.
module accum_alu
    import accum_cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sub,
    output logic [DW-1:0] y
);

    logic [DW-1:0] raw;

    assign raw = sub ? (a - b) : (a + b);

`ifdef ACC_SATURATE_EN
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    logic ovf;

    // Overflow always pushes the result away from a's sign, so a's MSB picks the rail.
    assign ovf = (sub ? (a[DW-1] != b[DW-1]) : (a[DW-1] == b[DW-1])) && (raw[DW-1] != a[DW-1]);
    assign y   = ovf ? (a[DW-1] ? SMIN : SMAX) : raw;
`else
    assign y = raw;
`endif

endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator processor core: fetch/execute FSM, instruction RAM, accumulator and INPUT handshake.
// Build option ACC_SATURATE_EN selects saturating ADD/SUB (see accum_alu).
module accum_cpu_core
    import accum_cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic [DW-1:0] data_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dataOut,
    output logic          Aeq0,
    output logic          Apos,
    output logic [2:0]    IR,
    output logic          halted,
    output logic          busy,
    output state_t        dbg_state
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    state_t        state, state_d;
    logic [AW-1:0] pc, pc_d;
    logic [DW-1:0] ir, ir_d;
    logic [DW-1:0] acc, acc_d;

    opcode_t       op;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] operand;
    logic [DW-1:0] alu_y;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign op      = opcode_t'(ir[DW-1 -: OPC_W]);
    assign op_addr = ir[AW-1:0];
    assign operand = mem[op_addr];

    accum_alu #(.DW(DW)) u_alu (
        .a   (acc),
        .b   (operand),
        .sub (op == OP_SUB),
        .y   (alu_y)
    );

    // INPUT handshake: data_in transfers at a rising edge where in_valid and in_ready
    // are both high. in_ready is high for the whole EXEC of INPUT and never depends on
    // in_valid; the core holds in EXEC until the transfer happens.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        ir_d      = ir;
        acc_d     = acc;
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                mem_we = prog_we;
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = mem[pc];
                pc_d    = pc + AW'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_LOAD:  acc_d = operand;
                    OP_STORE: begin
                        mem_we    = 1'b1;
                        mem_waddr = op_addr;
                        mem_wdata = acc;
                    end
                    OP_ADD,
                    OP_SUB:   acc_d = alu_y;
                    OP_INPUT: begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            acc_d = data_in;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_JZ:    if (Aeq0) pc_d = op_addr;
                    OP_JPOS:  if (Apos) pc_d = op_addr;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_FETCH;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            ir    <= ir_d;
            acc   <= acc_d;
        end
    end

    // RAM keeps its contents through reset; gating on rst_n drops a write that reset interrupts.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dataOut   = acc;
    assign Aeq0      = (acc == '0);
    assign Apos      = !acc[DW-1] && (acc != '0);
    assign IR        = ir[DW-1 -: OPC_W];
    assign halted    = (state == ST_HALT);
    assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
    assign dbg_state = state;

endmodule

// File: tb/tb_accum_cpu_core.sv
// Self-checking bench for accum_cpu_core: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_accum_cpu_core;
    import accum_cpu_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dataOut;
    logic          Aeq0;
    logic          Apos;
    logic [2:0]    IR;
    logic          halted;
    logic          busy;
    state_t        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] image   [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];

    accum_cpu_core #(.DW(DW), .AW(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataOut   (dataOut),
        .Aeq0      (Aeq0),
        .Apos      (Apos),
        .IR        (IR),
        .halted    (halted),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        prog_we = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic clear_image();
        for (int i = 0; i < DEPTH; i++) image[i] = '0;
    endtask

    task automatic load_image();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = image[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges after the start edge until halted is observed.
    task automatic wait_halt(input int budget, output int n);
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] arith(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sub);
        int sa, sb, s;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        s  = sub ? sa - sb : sa + sb;
`ifdef ACC_SATURATE_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return DW'(s);
    endfunction

    task automatic model_run(input logic [DW-1:0] din, output logic [DW-1:0] acc_o, output int cyc);
        int pc, op, ad;
        logic [DW-1:0] acc;
        bit done;
        pc = 0; acc = '0; cyc = 0; done = 0;
        while (!done && cyc < 1000) begin
            op  = int'(ref_mem[pc]) / 32;
            ad  = int'(ref_mem[pc]) % 32;
            pc  = (pc + 1) % DEPTH;
            cyc += 2;
            case (op)
                0: acc = ref_mem[ad];
                1: ref_mem[ad] = acc;
                2: acc = arith(acc, ref_mem[ad], 1'b0);
                3: acc = arith(acc, ref_mem[ad], 1'b1);
                4: acc = din;
                5: if (acc == 0) pc = ad;
                6: if (acc != 0 && acc < 128) pc = ad;
                default: done = 1;
            endcase
        end
        acc_o = acc;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; in_valid = 1'b0;
        prog_addr = '0; prog_data = '0; data_in = '0;
        #2;
        checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL reset_dataOut: got %0h want 0", dataOut); end
        checks++; if (Aeq0 !== 1'b1) begin errors++; $display("FAIL reset_Aeq0: got %b want 1", Aeq0); end
        checks++; if (Apos !== 1'b0) begin errors++; $display("FAIL reset_Apos: got %b want 0", Apos); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (halted !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_halted_busy: got %b%b want 00", halted, busy); end
        checks++; if (IR !== 3'b000) begin errors++; $display("FAIL reset_IR: got %b want 000", IR); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sum_program();
        clear_image();
        image[0] = enc(3'b000, 30); image[1] = enc(3'b010, 31);
        image[2] = enc(3'b001, 29); image[3] = enc(3'b111, 0);
        image[30] = 8'd10; image[31] = 8'd5;
        load_image();
        pulse_start();
        repeat (7) @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sum_halt_early: got %b want 0 after 8 edges", halted); end
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sum_halt_edge9: got %b want 1", halted); end
        checks++; if (dataOut !== 8'd15) begin errors++; $display("FAIL sum_dataOut: got %0d want 15", dataOut); end
        checks++; if (u_dut.mem[29] !== 8'd15) begin errors++; $display("FAIL sum_mem29: got %0d want 15", u_dut.mem[29]); end
        checks++; if (IR !== 3'b111) begin errors++; $display("FAIL sum_IR: got %b want 111", IR); end
    endtask

    task automatic test_input_handshake();
        int rdy_cnt, n;
        clear_image();
        image[0] = enc(3'b100, 0); image[1] = enc(3'b111, 0);
        in_valid = 1'b0; data_in = 8'd0;
        load_image();
        pulse_start();
        @(negedge clk);
        rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (in_ready === 1'b1) rdy_cnt++;
            // start and prog_we while busy must both be ignored
            start     = (k == 0);
            prog_we   = (k == 0);
            prog_addr = 5'd1;
            prog_data = enc(3'b000, 20);
            if (k == 3) begin in_valid = 1'b1; data_in = 8'd200; end
            @(negedge clk);
        end
        start = 1'b0; prog_we = 1'b0; in_valid = 1'b0;
        checks++; if (rdy_cnt != 4) begin errors++; $display("FAIL input_ready_cycles: got %0d want 4", rdy_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL input_ready_after: got %b want 0", in_ready); end
        wait_halt(50, n);
        checks++; if (n != 2) begin errors++; $display("FAIL input_halt_cycles: got %0d want 2", n); end
        checks++; if (dataOut !== 8'd200) begin errors++; $display("FAIL input_dataOut: got %0d want 200", dataOut); end
        checks++; if (Apos !== 1'b0 || Aeq0 !== 1'b0) begin errors++; $display("FAIL input_flags: got Apos=%b Aeq0=%b want 0 0", Apos, Aeq0); end
    endtask

    task automatic test_countdown();
        int n, iters;
        clear_image();
        image[0] = enc(3'b000, 20); image[1] = enc(3'b011, 21);
        image[2] = enc(3'b101, 4);  image[3] = enc(3'b110, 1);
        image[4] = enc(3'b111, 0);
        image[20] = 8'd3; image[21] = 8'd1;
        load_image();
        pulse_start();
        n = 0; iters = 0;
        while (halted !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (dbg_state == ST_EXEC && IR == 3'b011) iters++;
        end
        checks++; if (iters != 3) begin errors++; $display("FAIL countdown_iters: got %0d want 3", iters); end
        checks++; if (n != 20) begin errors++; $display("FAIL countdown_cycles: got %0d want 20", n); end
        checks++; if (dataOut !== 8'd0 || Aeq0 !== 1'b1) begin errors++; $display("FAIL countdown_final: got A=%0d Aeq0=%b want 0 1", dataOut, Aeq0); end
    endtask

    task automatic test_overflow();
        int n;
        logic [DW-1:0] want;
        for (int c = 0; c < 2; c++) begin
            clear_image();
            image[0] = enc(3'b000, 20);
            image[1] = enc((c == 0) ? 3'b010 : 3'b011, 21);
            image[2] = enc(3'b111, 0);
            image[20] = (c == 0) ? 8'd127 : 8'h80;
            image[21] = 8'd1;
`ifdef ACC_SATURATE_EN
            want = (c == 0) ? 8'd127 : 8'h80;
`else
            want = (c == 0) ? 8'h80 : 8'h7f;
`endif
            load_image();
            pulse_start();
            wait_halt(50, n);
            checks++; if (dataOut !== want) begin errors++; $display("FAIL overflow_case%0d: got %0h want %0h", c, dataOut, want); end
        end
    endtask

    task automatic test_same_edge();
        int n;
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = enc(3'b111, 0);
        start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_halt(50, n);
        checks++; if (n != 2) begin errors++; $display("FAIL same_edge_cycles: got %0d want 2", n); end
    endtask

    task automatic test_pc_wrap();
        int n;
        clear_image();
        image[0]  = enc(3'b000, 20); image[1] = enc(3'b001, 0);
        image[2]  = enc(3'b011, 20); image[3] = enc(3'b101, 31);
        image[31] = enc(3'b010, 21);
        image[20] = enc(3'b111, 0);  image[21] = 8'd7;
        load_image();
        pulse_start();
        wait_halt(100, n);
        checks++; if (n != 12) begin errors++; $display("FAIL wrap_cycles: got %0d want 12", n); end
        checks++; if (dataOut !== 8'd7) begin errors++; $display("FAIL wrap_dataOut: got %0d want 7", dataOut); end
    endtask

    task automatic test_reset_mid_store();
        clear_image();
        image[0] = enc(3'b000, 20); image[1] = enc(3'b001, 22); image[2] = enc(3'b111, 0);
        image[20] = 8'h5a; image[22] = 8'h11;
        load_image();
        pulse_start();
        repeat (3) @(negedge clk);
        checks++; if (dbg_state !== ST_EXEC || IR !== 3'b001) begin errors++; $display("FAIL midstore_setup: got state=%0d IR=%b want EXEC 001", dbg_state, IR); end
        rst_n = 1'b0;
        #1;
        checks++; if (dataOut !== 8'h00 || Aeq0 !== 1'b1 || Apos !== 1'b0) begin errors++; $display("FAIL midstore_acc: got %0h/%b/%b want 0/1/0", dataOut, Aeq0, Apos); end
        checks++; if (busy !== 1'b0 || halted !== 1'b0 || in_ready !== 1'b0 || IR !== 3'b000) begin errors++; $display("FAIL midstore_ctrl: got busy=%b halted=%b rdy=%b IR=%b want 0 0 0 000", busy, halted, in_ready, IR); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (u_dut.mem[22] !== 8'h11) begin errors++; $display("FAIL midstore_mem: got %0h want 11", u_dut.mem[22]); end
        @(negedge clk);
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midstore_state: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_random();
        int len, op, n, exp_cyc;
        logic [DW-1:0] exp_acc, din, want;
        for (int p = 0; p < 20; p++) begin
            do_reset();
            len = $urandom_range(12, 3);
            for (int i = 0; i < 16; i++) image[i] = enc(3'b111, 0);
            for (int i = 16; i < DEPTH; i++) image[i] = DW'($urandom);
            for (int i = 0; i < len; i++) begin
                op = $urandom_range(6, 0);
                if (op == 5 || op == 6) image[i] = enc(3'(op), AW'($urandom_range(len, i + 1)));
                else                    image[i] = enc(3'(op), AW'($urandom_range(31, 16)));
            end
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = image[i];
            din = DW'($urandom);
            data_in = din; in_valid = 1'b1;
            load_image();
            model_run(din, exp_acc, exp_cyc);
            for (int i = 16; i < DEPTH; i++) exp_q.push_back(ref_mem[i]);
            pulse_start();
            wait_halt(300, n);
            in_valid = 1'b0;
            checks++; if (n != exp_cyc) begin errors++; $display("FAIL rand%0d_cycles: got %0d want %0d", p, n, exp_cyc); end
            checks++; if (dataOut !== exp_acc) begin errors++; $display("FAIL rand%0d_acc: got %0h want %0h", p, dataOut, exp_acc); end
            checks++; if (Aeq0 !== (exp_acc == 0) || Apos !== (exp_acc != 0 && exp_acc < 128)) begin errors++; $display("FAIL rand%0d_flags: got %b%b for A=%0h", p, Aeq0, Apos, exp_acc); end
            checks++; if (IR !== 3'b111) begin errors++; $display("FAIL rand%0d_IR: got %b want 111", p, IR); end
            for (int i = 16; i < DEPTH; i++) begin
                want = exp_q.pop_front();
                checks++; if (u_dut.mem[i] !== want) begin errors++; $display("FAIL rand%0d_mem%0d: got %0h want %0h", p, i, u_dut.mem[i], want); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sum_program();
        test_input_handshake();
        test_countdown();
        test_overflow();
        test_same_edge();
        test_pc_wrap();
        test_reset_mid_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
